pin_collector: RTL and testbench

- Assembles a 4-digit PIN from single-cycle keypad events.
- On a valid ENTER, presents the PIN on a `pinPac_t` bus as a one-cycle `status` pulse.
- It is the producer side of `pinPac_t`. Master-PIN update, PIN verification and user-PIN programming blocks all consume its output directly on the same `clk`.

---
 rtl/lock_pkg.sv | 26 ++
 rtl/inactivity_timer.sv | 39 +++
 rtl/pin_collector.sv | 167 ++++++++++++++++
 tb/tb_pin_collector.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: types and constants shared by the lock's PIN producer and consumers.
//   pinPac_t  - submitted PIN bus: status (one-cycle submit pulse) + four 4-bit digits
//   KEY_*     - special keypad codes
//   PIN_LEN   - number of digits in a PIN
//   is_digit  - true for key codes 0x0-0x9
package lock_pkg;

  localparam int unsigned PIN_LEN = 4;

  localparam logic [3:0] KEY_BACK  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// inactivity_timer: counts idle cycles while run is high and flags expiry.
//   clk    in  - clock, rising edge
//   rst    in  - synchronous active-high reset
//   run    in  - count enable; low holds the counter at 0
//   kick   in  - activity seen; restarts the count and suppresses expiry
//   expire out - one-cycle pulse in the cycle the count sits at CYCLES-1 with no kick
module inactivity_timer #(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire
);

  logic [31:0] cnt_q, cnt_d;
  logic        at_limit;

  assign at_limit = (cnt_q == CYCLES - 1);
  // Combinational so the owner can register its timeout on the very next edge.
  assign expire   = run && !kick && at_limit;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (!run || kick || at_limit) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pin_collector.sv
// pin_collector: assembles a 4-digit PIN from keypad strobes and submits it on ENTER.
//   TIMEOUT_CYCLES  - inactivity limit in clk cycles (used only with PIN_TIMEOUT_EN)
//   clk             in  - clock, rising edge
//   rst             in  - synchronous active-high reset
//   enable          in  - collection permitted; low forces idle and discards partial entry
//   key_valid       in  - one-cycle strobe qualifying key_code
//   key_code        in  - 0-9 digit, A BACK, E CLEAR, F ENTER, B-D ignored
//   pin_out         out - pinPac_t; status pulses one cycle on submit, digits hold last PIN
//   digit_count     out - digits currently held (0-4)
//   key_error       out - one-cycle pulse on a rejected key
//   timeout         out - one-cycle pulse when a partial entry is abandoned
// Optional feature: define PIN_TIMEOUT_EN to build the inactivity timeout.
module pin_collector
  import lock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output pinPac_t    pin_out,
  output logic [2:0] digit_count,
  output logic       key_error,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StCollect, StFull, StSend} state_e;

  localparam logic [2:0] FullCount = 3'(PIN_LEN);

  state_e                      state_q, state_d;
  logic [2:0]                  count_q, count_d;
  logic [PIN_LEN-1:0][3:0]     slot_q, slot_d;    // slot 0 holds the first key pressed
  pinPac_t                     pin_q, pin_d;
  logic                        key_error_q, key_error_d;
  logic                        timeout_q, timeout_d;
  logic                        expire;

`ifdef PIN_TIMEOUT_EN
  logic run;

  // Only a partial entry can be abandoned; an empty one has nothing to discard.
  assign run = ((state_q == StCollect) || (state_q == StFull)) && (count_q != 3'd0);

  inactivity_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_inactivity_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .kick   (key_valid),
    .expire (expire)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire             = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    slot_d      = slot_q;
    pin_d       = pin_q;
    pin_d.status = 1'b0;
    key_error_d = 1'b0;
    timeout_d   = 1'b0;

    if (!enable) begin
      // Takes priority over any same-cycle key; submitted digits are kept.
      state_d = StIdle;
      count_d = 3'd0;
      slot_d  = '0;
    end else begin
      unique case (state_q)
        StIdle, StSend: begin
          // Keys are dropped here; a fresh entry starts next cycle.
          state_d = StCollect;
          count_d = 3'd0;
          slot_d  = '0;
        end
        StCollect, StFull: begin
          if (key_valid) begin
            if (is_digit(key_code)) begin
              if (state_q == StFull) begin
                key_error_d = 1'b1;
              end else begin
                slot_d[count_q[1:0]] = key_code;
                count_d              = count_q + 3'd1;
                if (count_q == FullCount - 3'd1) begin
                  state_d = StFull;
                end
              end
            end else begin
              case (key_code)
                KEY_BACK: begin
                  if (count_q != 3'd0) begin
                    // With count 4 the low bits wrap to 0, so minus one lands on slot 3.
                    slot_d[count_q[1:0] - 2'd1] = 4'd0;
                    count_d                     = count_q - 3'd1;
                    state_d                     = StCollect;
                  end else begin
                    key_error_d = 1'b1;
                  end
                end
                KEY_CLEAR: begin
                  state_d = StCollect;
                  count_d = 3'd0;
                  slot_d  = '0;
                end
                KEY_ENTER: begin
                  if (state_q == StFull) begin
                    pin_d.status = 1'b1;
                    pin_d.digit1 = slot_q[0];
                    pin_d.digit2 = slot_q[1];
                    pin_d.digit3 = slot_q[2];
                    pin_d.digit4 = slot_q[3];
                    state_d      = StSend;
                  end else begin
                    key_error_d = 1'b1;
                    state_d     = StCollect;
                  end
                  count_d = 3'd0;
                  slot_d  = '0;
                end
                default: ;  // 0xB-0xD have no effect
              endcase
            end
          end else if (expire) begin
            state_d   = StCollect;
            count_d   = 3'd0;
            slot_d    = '0;
            timeout_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= 3'd0;
      slot_q      <= '0;
      pin_q       <= '0;
      key_error_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      slot_q      <= slot_d;
      pin_q       <= pin_d;
      key_error_q <= key_error_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pin_out     = pin_q;
  assign digit_count = count_q;
  assign key_error   = key_error_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pin_collector.sv
// tb_pin_collector: self-checking bench for pin_collector. Expected submitted PINs are
// queued when ENTER is driven and popped by a monitor whenever status pulses.
module tb_pin_collector;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       key_valid;
  logic [3:0] key_code;
  pinPac_t    pin_out;
  logic [2:0] digit_count;
  logic       key_error;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  pinPac_t exp_q[$];

  always #5 clk = ~clk;

  pin_collector #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .pin_out     (pin_out),
    .digit_count (digit_count),
    .key_error   (key_error),
    .timeout     (timeout)
  );

  // Scoreboard consumer: every status pulse must match the oldest queued submit.
  always @(negedge clk) begin
    if (pin_out.status === 1'b1) begin
      pinPac_t exp;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL submit_unexpected got=%h want=none", pin_out);
      end else begin
        exp = exp_q.pop_front();
        if (pin_out !== exp) begin
          bad++;
          $display("FAIL submit_data got=%h want=%h", pin_out, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) tick();
    rst = 1'b0;
    total++;
    if (pin_out !== '0 || digit_count !== 3'd0 || key_error !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset got pin=%h cnt=%0d err=%b to=%b want 0", pin_out, digit_count,
               key_error, timeout);
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_submit();
    logic [3:0] d;
    for (int i = 1; i <= 4; i++) begin
      d = 4'(i);
      press(d);
      total++;
      if (digit_count !== 3'(i)) begin
        bad++;
        $display("FAIL submit_count got=%0d want=%0d", digit_count, i);
      end
    end
    exp_q.push_back('{status: 1'b1, digit1: 4'd1, digit2: 4'd2, digit3: 4'd3, digit4: 4'd4});
    press(KEY_ENTER);
    total++;
    if (pin_out.status !== 1'b1) begin
      bad++;
      $display("FAIL submit_status got=%b want=1", pin_out.status);
    end
    // Key during the SEND cycle must be dropped.
    press(4'd7);
    total++;
    if (pin_out.status !== 1'b0 || digit_count !== 3'd0 || key_error !== 1'b0) begin
      bad++;
      $display("FAIL submit_after got st=%b cnt=%0d err=%b want 0/0/0", pin_out.status,
               digit_count, key_error);
    end
    total++;
    if (pin_out !== 17'h01234) begin
      bad++;
      $display("FAIL submit_hold got=%h want=01234", pin_out);
    end
  endtask

  task automatic test_short_enter();
    press(4'd7);
    press(4'd8);
    total++;
    if (digit_count !== 3'd2) begin
      bad++;
      $display("FAIL short_count got=%0d want=2", digit_count);
    end
    press(KEY_ENTER);
    total++;
    if (key_error !== 1'b1 || digit_count !== 3'd0 || pin_out.status !== 1'b0) begin
      bad++;
      $display("FAIL short_enter got err=%b cnt=%0d st=%b want 1/0/0", key_error,
               digit_count, pin_out.status);
    end
    tick();
    total++;
    if (key_error !== 1'b0 || pin_out !== 17'h01234) begin
      bad++;
      $display("FAIL short_after got err=%b pin=%h want 0/01234", key_error, pin_out);
    end
  endtask

  task automatic test_fifth_back();
    for (int i = 1; i <= 4; i++) press(4'(i));
    press(4'd9);
    total++;
    if (key_error !== 1'b1 || digit_count !== 3'd4) begin
      bad++;
      $display("FAIL fifth_digit got err=%b cnt=%0d want 1/4", key_error, digit_count);
    end
    press(KEY_BACK);
    total++;
    if (key_error !== 1'b0 || digit_count !== 3'd3) begin
      bad++;
      $display("FAIL back got err=%b cnt=%0d want 0/3", key_error, digit_count);
    end
    press(4'd5);
    exp_q.push_back('{status: 1'b1, digit1: 4'd1, digit2: 4'd2, digit3: 4'd3, digit4: 4'd5});
    press(KEY_ENTER);
    total++;
    if (pin_out.status !== 1'b1) begin
      bad++;
      $display("FAIL back_submit got=%b want=1", pin_out.status);
    end
    tick();
    press(KEY_BACK);
    total++;
    if (key_error !== 1'b1 || digit_count !== 3'd0) begin
      bad++;
      $display("FAIL back_empty got err=%b cnt=%0d want 1/0", key_error, digit_count);
    end
  endtask

  task automatic test_clear_ignored();
    press(4'd6);
    press(4'hC);
    total++;
    if (digit_count !== 3'd1 || key_error !== 1'b0) begin
      bad++;
      $display("FAIL ignored got cnt=%0d err=%b want 1/0", digit_count, key_error);
    end
    press(4'd2);
    press(KEY_CLEAR);
    total++;
    if (digit_count !== 3'd0 || key_error !== 1'b0) begin
      bad++;
      $display("FAIL clear got cnt=%0d err=%b want 0/0", digit_count, key_error);
    end
  endtask

  task automatic test_timeout();
`ifdef PIN_TIMEOUT_EN
    int early = 0;
    press(4'd3);
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (timeout !== 1'b0 || digit_count !== 3'd1) early++;
    end
    tick();
    total++;
    if (early != 0 || timeout !== 1'b1 || digit_count !== 3'd0 || key_error !== 1'b0) begin
      bad++;
      $display("FAIL timeout_fire got early=%0d to=%b cnt=%0d err=%b want 0/1/0/0", early,
               timeout, digit_count, key_error);
    end
    tick();
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_width got=%b want=0", timeout);
    end
    early = 0;
    press(4'd3);
    repeat (6) tick();
    press(4'd4);
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (timeout !== 1'b0 || digit_count !== 3'd2) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL timeout_kick got early=%0d want=0", early);
    end
    tick();
    total++;
    if (timeout !== 1'b1 || digit_count !== 3'd0) begin
      bad++;
      $display("FAIL timeout_refire got to=%b cnt=%0d want 1/0", timeout, digit_count);
    end
`else
    int seen = 0;
    press(4'd3);
    repeat (20) begin
      tick();
      if (timeout !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || digit_count !== 3'd1) begin
      bad++;
      $display("FAIL no_timeout got pulses=%0d cnt=%0d want 0/1", seen, digit_count);
    end
    press(KEY_CLEAR);
`endif
  endtask

  task automatic test_enable_drop();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    enable = 1'b0;
    tick();
    total++;
    if (digit_count !== 3'd0 || key_error !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL enable_drop got cnt=%0d err=%b to=%b want 0/0/0", digit_count,
               key_error, timeout);
    end
    press(4'd5);
    total++;
    if (digit_count !== 3'd0 || key_error !== 1'b0 || pin_out !== 17'h01235) begin
      bad++;
      $display("FAIL idle_key got cnt=%0d err=%b pin=%h want 0/0/01235", digit_count,
               key_error, pin_out);
    end
    enable = 1'b1;
    tick();
    press(4'd9);
    total++;
    if (digit_count !== 3'd1) begin
      bad++;
      $display("FAIL reenable got cnt=%0d want=1", digit_count);
    end
    press(KEY_CLEAR);
  endtask

  task automatic test_rst_in_send();
    press(4'd4);
    press(4'd3);
    press(4'd2);
    press(4'd1);
    exp_q.push_back('{status: 1'b1, digit1: 4'd4, digit2: 4'd3, digit3: 4'd2, digit4: 4'd1});
    press(KEY_ENTER);
    total++;
    if (pin_out.status !== 1'b1) begin
      bad++;
      $display("FAIL send_status got=%b want=1", pin_out.status);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (pin_out !== '0 || digit_count !== 3'd0 || key_error !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_send got pin=%h cnt=%0d err=%b to=%b want 0", pin_out,
               digit_count, key_error, timeout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_submit();
    test_short_enter();
    test_fifth_back();
    test_clear_ignored();
    test_timeout();
    test_enable_drop();
    test_rst_in_send();
    repeat (2) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL submits_missing got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
